// File: rtl/vending_machine_param.sv
// Parametrised vending machine: debounced coin inputs, configurable price and coin values,
// change return, refund on Enable withdrawal and overflow rejection.
module vending_machine_param #(
  parameter int NUM_COINS = 4,
  parameter int MONEY_W = 8,
  parameter logic [NUM_COINS*MONEY_W-1:0] COIN_VALUES = {8'd100, 8'd50, 8'd10, 8'd5},
  parameter int PRICE = 150,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Enable,
  input  logic [NUM_COINS-1:0] Coins,
  output logic                 Deliver,
  output logic [MONEY_W-1:0]   Money,
  output logic [MONEY_W-1:0]   Change,
  output logic                 ChangeValid,
  output logic                 Reject
);

  localparam int SUM_W = MONEY_W + $clog2(NUM_COINS) + 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SUM_W-1:0] MONEY_MAX = SUM_W'({MONEY_W{1'b1}});
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND} stateType;

  stateType state, nextState;

  logic [NUM_COINS-1:0] sync1, sync2, level, levelDly, coinPulse;
  logic [CNT_W-1:0]     stableCnt [NUM_COINS];

  logic [SUM_W-1:0]   coinSum, sum;
  logic [MONEY_W-1:0] moneyNext, changeNext;
  logic               deliverNext, changeValidNext, rejectNext;

  // Level only moves after DEBOUNCE_CYCLES consecutive samples disagreeing with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1     <= '0;
      sync2     <= '0;
      level     <= '0;
      levelDly  <= '0;
      coinPulse <= '0;
      for (int i = 0; i < NUM_COINS; i++) stableCnt[i] <= '0;
    end else begin
      sync1     <= Coins;
      sync2     <= sync1;
      levelDly  <= level;
      coinPulse <= level & ~levelDly;
      for (int i = 0; i < NUM_COINS; i++) begin
        if (sync2[i] != level[i]) begin
          if (stableCnt[i] == CNT_LAST) begin
            level[i]     <= sync2[i];
            stableCnt[i] <= '0;
          end else begin
            stableCnt[i] <= stableCnt[i] + 1'b1;
          end
        end else begin
          stableCnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    coinSum = '0;
    for (int i = 0; i < NUM_COINS; i++)
      if (coinPulse[i]) coinSum = coinSum + SUM_W'(COIN_VALUES[i*MONEY_W +: MONEY_W]);
    sum = SUM_W'(Money) + coinSum;
  end

  always_comb begin
    nextState       = state;
    moneyNext       = Money;
    changeNext      = Change;
    deliverNext     = 1'b0;
    changeValidNext = 1'b0;
    rejectNext      = 1'b0;
    case (state)
      IDLE: begin
        if (Enable) nextState = COLLECT;
      end
      COLLECT: begin
        if (!Enable) begin
          nextState = IDLE;
          if (Money != '0) begin
            changeNext      = Money;
            changeValidNext = 1'b1;
            moneyNext       = '0;
          end
        end else if (sum > MONEY_MAX) begin
          rejectNext = 1'b1;
        end else begin
          moneyNext = sum[MONEY_W-1:0];
          if (sum >= SUM_W'(PRICE)) nextState = VEND;
        end
      end
      VEND: begin
        // The vend completes even if Enable has just been withdrawn.
        deliverNext     = 1'b1;
        changeValidNext = 1'b1;
        changeNext      = Money - MONEY_W'(PRICE);
        moneyNext       = '0;
        rejectNext      = |coinPulse;
        nextState       = Enable ? COLLECT : IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      Money       <= '0;
      Change      <= '0;
      Deliver     <= 1'b0;
      ChangeValid <= 1'b0;
      Reject      <= 1'b0;
    end else begin
      state       <= nextState;
      Money       <= moneyNext;
      Change      <= changeNext;
      Deliver     <= deliverNext;
      ChangeValid <= changeValidNext;
      Reject      <= rejectNext;
    end
  end

endmodule

// File: tb/tb_vending_machine_param.sv
// Directed self-checking bench for vending_machine_param: default instance plus a PRICE=255
// instance used for the overflow-rejection scenario.
module tb_vending_machine_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [3:0] coins = 4'b0;

  logic       deliver, changeValid, reject;
  logic [7:0] money, change;
  logic       deliver2, changeValid2, reject2;
  logic [7:0] money2, change2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vending_machine_param dut (
    .CLK(clk), .RST(rst), .Enable(enable), .Coins(coins),
    .Deliver(deliver), .Money(money), .Change(change),
    .ChangeValid(changeValid), .Reject(reject)
  );

  vending_machine_param #(.PRICE(255)) dutMax (
    .CLK(clk), .RST(rst), .Enable(enable), .Coins(coins),
    .Deliver(deliver2), .Money(money2), .Change(change2),
    .ChangeValid(changeValid2), .Reject(reject2)
  );

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a coin mask and stop just after the edge preceding the expected Money update.
  task automatic applyStimulus(input logic [3:0] mask);
    coins = mask;
    repeat (7) @(posedge clk);
    #1;
  endtask

  task automatic releaseCoins();
    coins = 4'b0;
    repeat (8) step();
  endtask

  task automatic doReset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_money", money, 0);
    checkOutput("rst_change", change, 0);
    checkOutput("rst_deliver", deliver, 0);
    checkOutput("rst_changeValid", changeValid, 0);
    checkOutput("rst_reject", reject, 0);
    rst = 1'b0;

    $display("[TB] scenario 1: 100 then 50 vends exactly");
    enable = 1'b1;
    applyStimulus(4'b1000);
    checkOutput("s1_latency_before", money, 0);
    step();
    checkOutput("s1_money100", money, 100);
    releaseCoins();
    applyStimulus(4'b0100);
    step();
    checkOutput("s1_money150", money, 150);
    checkOutput("s1_noDeliverYet", deliver, 0);
    step();
    checkOutput("s1_deliver", deliver, 1);
    checkOutput("s1_changeValid", changeValid, 1);
    checkOutput("s1_change", change, 0);
    checkOutput("s1_moneyCleared", money, 0);
    step();
    checkOutput("s1_deliverDrop", deliver, 0);
    checkOutput("s1_changeValidDrop", changeValid, 0);
    releaseCoins();

    $display("[TB] scenario 2: overpay change and simultaneous coins");
    applyStimulus(4'b1000);
    step();
    checkOutput("s2_money100", money, 100);
    releaseCoins();
    applyStimulus(4'b1000);
    step();
    checkOutput("s2_money200", money, 200);
    step();
    checkOutput("s2_deliver", deliver, 1);
    checkOutput("s2_change50", change, 50);
    checkOutput("s2_moneyCleared", money, 0);
    releaseCoins();
    applyStimulus(4'b0011);
    checkOutput("s2_simul_before", money, 0);
    step();
    checkOutput("s2_simul15", money, 15);
    releaseCoins();

    $display("[TB] scenario 3: bounce and glitch filtering");
    doReset();
    for (int i = 0; i < 6; i++) begin
      coins[0] = (i % 2 == 0);
      step();
    end
    applyStimulus(4'b0001);
    checkOutput("s3_bounce_before", money, 0);
    step();
    checkOutput("s3_oneNickel", money, 5);
    repeat (20) step();
    checkOutput("s3_heldOnce", money, 5);
    coins = 4'b0;
    repeat (8) step();
    coins = 4'b0001;
    repeat (3) step();
    coins = 4'b0;
    repeat (12) step();
    checkOutput("s3_glitchIgnored", money, 5);
    checkOutput("s3_noReject", reject, 0);

    $display("[TB] scenario 4: refund on Enable withdrawal");
    doReset();
    applyStimulus(4'b0100);
    step();
    releaseCoins();
    applyStimulus(4'b0010);
    step();
    checkOutput("s4_money60", money, 60);
    releaseCoins();
    enable = 1'b0;
    step();
    checkOutput("s4_changeValid", changeValid, 1);
    checkOutput("s4_change60", change, 60);
    checkOutput("s4_moneyCleared", money, 0);
    checkOutput("s4_noDeliver", deliver, 0);
    step();
    checkOutput("s4_changeValidDrop", changeValid, 0);
    applyStimulus(4'b1000);
    step();
    checkOutput("s4_idleMoney", money, 0);
    checkOutput("s4_idleReject", reject, 0);
    releaseCoins();

    $display("[TB] scenario 5: overflow rejection with PRICE=255");
    doReset();
    enable = 1'b1;
    applyStimulus(4'b1000);
    step();
    releaseCoins();
    applyStimulus(4'b1000);
    step();
    checkOutput("s5_money200", money2, 200);
    releaseCoins();
    applyStimulus(4'b1000);
    step();
    checkOutput("s5_reject", reject2, 1);
    checkOutput("s5_moneyHeld", money2, 200);
    step();
    checkOutput("s5_rejectDrop", reject2, 0);
    releaseCoins();
    applyStimulus(4'b0100);
    step();
    checkOutput("s5_money250", money2, 250);
    checkOutput("s5_noDeliver", deliver2, 0);
    releaseCoins();

    $display("[TB] scenario 6: reset mid-collection");
    doReset();
    applyStimulus(4'b1000);
    step();
    releaseCoins();
    applyStimulus(4'b1000);
    step();
    step();
    checkOutput("s6_change50", change, 50);
    releaseCoins();
    applyStimulus(4'b1000);
    step();
    releaseCoins();
    applyStimulus(4'b0010);
    step();
    checkOutput("s6_money110", money, 110);
    releaseCoins();
    doReset();
    checkOutput("s6_rstMoney", money, 0);
    checkOutput("s6_rstChange", change, 0);
    checkOutput("s6_rstChangeValid", changeValid, 0);
    checkOutput("s6_rstDeliver", deliver, 0);
    checkOutput("s6_rstReject", reject, 0);
    step();
    checkOutput("s6_noRefund", changeValid, 0);
    applyStimulus(4'b1000);
    step();
    checkOutput("s6_money100", money, 100);
    releaseCoins();
    applyStimulus(4'b0100);
    step();
    checkOutput("s6_money150", money, 150);
    step();
    checkOutput("s6_deliver", deliver, 1);
    checkOutput("s6_change0", change, 0);
    checkOutput("s6_moneyCleared", money, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vending_machine_param.md
# vending_machine_param

Parametrised successor to the four-coin vending top. It integrates per-channel debouncing and rising-edge coin detection with a configurable price and configurable coin values. It adds change return, refund on Enable withdrawal and overflow rejection. It sits directly on the raw push-button coin inputs and drives the delivery and money displays.

## Interface

**Parameters**

- `NUM_COINS`, default 4: number of coin channels.
- `MONEY_W`, default 8: width of money accumulator, coin values, price and change.
- `COIN_VALUES`, default `{8'd100, 8'd50, 8'd10, 8'd5}`: packed `NUM_COINS*MONEY_W`. Channel i value is `[i*MONEY_W +: MONEY_W]`, so channel 0 = 5 and channel 3 = 100.
- `PRICE`, default 150: item price. Legal range is 1..2^MONEY_W-1.
- `DEBOUNCE_CYCLES`, default 4: consecutive identical synchronised samples required to change a debounced level. Minimum 1.

**Ports**

- `CLK` input 1: single clock. Rising edge only.
- `RST` input 1: synchronous, active-high reset.
- `Enable` input 1: machine enabled. Sampled each edge.
- `Coins` input `NUM_COINS`: raw, bouncy, asynchronous button levels. Bit i is channel i.
- `Deliver` output 1: one-cycle pulse when the item is dispensed.
- `Money` output `MONEY_W`: current accumulated credit.
- `Change` output `MONEY_W`: last change/refund amount. Held until the next `ChangeValid`.
- `ChangeValid` output 1: one-cycle pulse when `Change` is loaded.
- `Reject` output 1: one-cycle pulse when a coin event is discarded.

## Operation

**Reset**
- On RST=1 at an edge, all of the following clear to 0: `Deliver`, `Money`, `Change`, `ChangeValid`, `Reject`, synchronisers, debounce counters, debounced levels and coin pulses.
- State goes to IDLE.
- No refund is issued on reset.

**Per-channel front end**
- 2-flop synchroniser, then the stability counter.
- The debounced level takes the synchronised value after `DEBOUNCE_CYCLES` consecutive equal samples that differ from the current level.
- A registered coin pulse fires for one cycle on a debounced rising edge.
- A button held through reset yields one event after debounce.

**States: IDLE, COLLECT, VEND**
- **IDLE**
  - Coin pulses are ignored. `Reject` stays 0.
  - Enable=1 moves to COLLECT.
- **COLLECT, Enable=1**
  - `sum` = `Money` + values of all coin pulses this cycle. Simultaneous pulses are summed.
  - `sum` is computed in `MONEY_W`+clog2(`NUM_COINS`)+1 bits.
  - If `sum` > 2^`MONEY_W`-1, all pulses this cycle are discarded, `Money` is unchanged and `Reject` pulses.
  - Otherwise `Money`=`sum`. If `sum` >= `PRICE`, go to VEND.
- **COLLECT, Enable=0**
  - Coin pulses this cycle are ignored, with no `Reject`.
  - If `Money` > 0: `Change`=`Money`, `ChangeValid`=1, `Money`=0.
  - Go to IDLE.
- **VEND** (exactly one cycle)
  - At the next edge: `Deliver`=1, `ChangeValid`=1, `Change`=`Money`-`PRICE`, `Money`=0.
  - Any coin pulse in this cycle is discarded and `Reject` pulses.
  - Next state is COLLECT if Enable=1, else IDLE. A vend already in progress completes regardless of Enable.

## Timing

- Coin latency:
  - Raw channel first sampled high at edge t and held stable.
  - Debounced level rises at edge t+1+`DEBOUNCE_CYCLES`.
  - Coin pulse at t+2+`DEBOUNCE_CYCLES`.
  - `Money` updated at t+3+`DEBOUNCE_CYCLES`, which is 7 edges for the default.
- Vend:
  - `Money` reaches >= `PRICE` at edge k.
  - At edge k+1, `Deliver`/`ChangeValid` go high and `Money` goes to 0.
  - At edge k+2, both pulses return to 0.
- Refund: Enable=0 sampled at edge k in COLLECT. At that edge `ChangeValid`=1 and `Money`=0; it drops at k+1.
- `Deliver`, `ChangeValid` and `Reject` are never high for two consecutive cycles from a single event.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- A held button produces exactly one event. A new event needs release (debounced low) and then press again.

## Test plan

1. Defaults, Enable=1, press ch3 (100) then ch2 (50) → `Money` 100 then 150; next cycle `Deliver`=1, `ChangeValid`=1, `Change`=0, `Money`=0.
2. Press ch3 twice → `Money` 200, then `Deliver`=1, `Change`=50. Next, press ch0 and ch1 released into stable high simultaneously → `Money` 15 in a single update.
3. Bounce on ch0: toggle every cycle for 6 cycles, then hold high 20 cycles → exactly one +5, `Money`=5 at `DEBOUNCE_CYCLES`+3 edges after the final rise; a 3-cycle glitch produces nothing.
4. `Money`=60 in COLLECT, drop Enable → `ChangeValid`=1 for one cycle, `Change`=60, `Money`=0, `Deliver`=0; later coins in IDLE leave `Money`=0 and `Reject`=0.
5. `PRICE`=255, `MONEY_W`=8: reach 200, insert 100 → `Reject`=1 for one cycle, `Money` stays 200; insert 50 → `Money`=250.
6. `Money`=110, assert RST for one cycle → all outputs 0, no `ChangeValid`, state IDLE; Enable=1 and 150 inserted afterwards vends normally.
